// File: rtl/gesture_output_pio.sv
// Avalon-MM output PIO: DATA register driving out_port, atomic set/clear,
// and a retriggerable one-shot pulse timer that auto-clears its mask bits.
module gesture_output_pio #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH    = 16,
    parameter int                    DEFAULT_PLEN = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic [2:0]            address,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_active
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_PLEN  = 3'd1;
    localparam logic [2:0] A_STAT  = 3'd2;
    localparam logic [2:0] A_MASK  = 3'd3;
    localparam logic [2:0] A_SET   = 3'd4;
    localparam logic [2:0] A_CLR   = 3'd5;
    localparam logic [2:0] A_PULSE = 3'd6;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  plen_q, plen_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  wr_s;
    logic                  trig_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [CNT_WIDTH-1:0]  load_s;
    logic                  unused_s;

    assign wr_s     = chipselect & ~write_n;
    assign wd_s     = writedata[DATA_WIDTH-1:0];
    assign trig_s   = wr_s && (address == A_PULSE) && (wd_s != {DATA_WIDTH{1'b0}});
    assign load_s   = (plen_q == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : plen_q;
    assign unused_s = ^writedata;

    // Next-state: timer step first, then the bus write layered on top by priority
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        plen_d  = plen_q;
        cnt_d   = cnt_q;
        // A retrigger reloads the counter, so it suppresses this cycle's step/expiry
        if (state_q == RUN && !trig_s) begin
            if (cnt_q <= CNT_WIDTH'(1)) begin
                data_d  = data_q & ~mask_q;
                mask_d  = {DATA_WIDTH{1'b0}};
                cnt_d   = {CNT_WIDTH{1'b0}};
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (wr_s) begin
            case (address)
                A_DATA: begin
                    data_d  = wd_s;
                    mask_d  = {DATA_WIDTH{1'b0}};
                    cnt_d   = {CNT_WIDTH{1'b0}};
                    state_d = IDLE;
                end
                A_PLEN:  plen_d = writedata[CNT_WIDTH-1:0];
                A_SET:   data_d = data_d | wd_s;
                A_CLR: begin
                    data_d = data_d & ~wd_s;
                    mask_d = mask_d & ~wd_s;
                    if (mask_d == {DATA_WIDTH{1'b0}}) begin
                        cnt_d   = {CNT_WIDTH{1'b0}};
                        state_d = IDLE;
                    end else begin
                        state_d = state_d;
                    end
                end
                A_PULSE: begin
                    if (trig_s) begin
                        data_d  = data_q | wd_s;
                        mask_d  = mask_q | wd_s;
                        cnt_d   = load_s;
                        state_d = RUN;
                    end else begin
                        state_d = state_d;
                    end
                end
                default: state_d = state_d;
            endcase
        end else begin
            state_d = state_d;
        end
    end

    // Read mux, zero-extended; sampled every cycle regardless of chipselect
    always_comb begin
        rdata_d = 32'd0;
        case (address)
            A_DATA:  rdata_d[DATA_WIDTH-1:0] = data_q;
            A_PLEN:  rdata_d[CNT_WIDTH-1:0]  = plen_q;
            A_STAT:  rdata_d[0]              = (state_q == RUN);
            A_MASK:  rdata_d[DATA_WIDTH-1:0] = mask_q;
            default: rdata_d = 32'd0;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= RESET_VALUE;
            mask_q  <= {DATA_WIDTH{1'b0}};
            plen_q  <= CNT_WIDTH'(DEFAULT_PLEN);
            cnt_q   <= {CNT_WIDTH{1'b0}};
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata     = rdata_q;
    assign out_port     = data_q;
    assign pulse_active = (state_q == RUN);

endmodule

// File: tb/tb_gesture_output_pio.sv
// Directed self-checking bench for gesture_output_pio (DATA_WIDTH=8, RESET_VALUE=A5).
module tb_gesture_output_pio;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_active;

    int vectors;
    int errors;

    gesture_output_pio #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (8'hA5),
        .CNT_WIDTH   (16),
        .DEFAULT_PLEN(1000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chipselect  (chipselect),
        .address     (address),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_port    (out_port),
        .pulse_active(pulse_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_port !== 8'hA5 || pulse_active !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: out=%h act=%b rd=%h, want A5 0 0", out_port, pulse_active, readdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(3'd1, rd);
        vectors++;
        if (rd !== 32'd1000) begin
            errors++;
            $display("FAIL reset_plen: got %0d want 1000", rd);
        end
        bus_read(3'd2, rd);
        vectors++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got %h want 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  exp [3] = '{8'h3C, 8'hFF, 8'hF0};
        logic [2:0]  adr [3] = '{3'd0, 3'd4, 3'd5};
        logic [31:0] wdt [3] = '{32'hFFFF_FF3C, 32'h0000_00C3, 32'h0000_000F};
        for (int i = 0; i < 3; i++) begin
            bus_write(adr[i], wdt[i]);
            vectors++;
            if (out_port !== exp[i]) begin
                errors++;
                $display("FAIL set_clear_%0d: got %h want %h", i, out_port, exp[i]);
            end
        end
        bus_read(3'd0, rd);
        vectors++;
        if (rd !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL read_data: got %h want 000000F0", rd);
        end
        // Ignored writes to STATUS and MASK, and addr 7 reads zero
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, rd);
        vectors++;
        if (out_port !== 8'hF0 || pulse_active !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL ignored_writes: out=%h act=%b rd7=%h, want F0 0 0", out_port, pulse_active, rd);
        end
    endtask

    // Triggers mask m with pulse length len from DATA=0 and counts high cycles
    task automatic test_pulse(input logic [15:0] len, input logic [7:0] m, input int want_hi);
        int hi;
        int act;
        bus_write(3'd1, {16'd0, len});
        bus_write(3'd0, 32'd0);
        bus_write(3'd6, {24'd0, m});
        hi  = 0;
        act = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_port === m) hi++;
            if (pulse_active === 1'b1) act++;
            @(negedge clk);
        end
        vectors++;
        if (hi != want_hi || act != want_hi || out_port !== 8'h00) begin
            errors++;
            $display("FAIL pulse_len%0d: high=%0d active=%0d out=%h, want %0d %0d 00", len, hi, act, out_port, want_hi, want_hi);
        end
    endtask

    task automatic test_zero_len_status();
        logic [31:0] rd;
        test_pulse(16'd0, 8'h80, 1);
        bus_read(3'd2, rd);
        vectors++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL status_after_pulse: got %h want 0", rd);
        end
        bus_write(3'd6, 32'd0);
        vectors++;
        if (pulse_active !== 1'b0 || out_port !== 8'h00) begin
            errors++;
            $display("FAIL zero_trigger: act=%b out=%h want 0 00", pulse_active, out_port);
        end
    endtask

    task automatic test_retrigger();
        logic [31:0] rd;
        int both;
        bus_write(3'd1, 32'd10);
        bus_write(3'd0, 32'd0);
        bus_write(3'd6, 32'h01);
        repeat (3) @(negedge clk);
        bus_write(3'd6, 32'h02);
        both = 1;
        bus_read(3'd3, rd);
        vectors++;
        if (rd !== 32'h03) begin
            errors++;
            $display("FAIL retrig_mask: got %h want 03", rd);
        end
        for (int i = 0; i < 30; i++) begin
            if (out_port === 8'h03) both++;
            @(negedge clk);
        end
        vectors++;
        if (both != 10 || out_port !== 8'h00) begin
            errors++;
            $display("FAIL retrigger: both-high=%0d out=%h want 10 00", both, out_port);
        end
    endtask

    task automatic test_cancel();
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'd0);
        bus_write(3'd6, 32'h01);
        bus_write(3'd0, 32'h55);
        vectors++;
        if (pulse_active !== 1'b0 || out_port !== 8'h55) begin
            errors++;
            $display("FAIL data_cancel: act=%b out=%h want 0 55", pulse_active, out_port);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (out_port !== 8'h55) begin
            errors++;
            $display("FAIL data_hold: got %h want 55", out_port);
        end
        // OUTCLEAR emptying the mask ends the pulse
        bus_write(3'd6, 32'h02);
        bus_write(3'd5, 32'h02);
        vectors++;
        if (pulse_active !== 1'b0 || out_port !== 8'h55) begin
            errors++;
            $display("FAIL clear_cancel: act=%b out=%h want 0 55", pulse_active, out_port);
        end
        // Asynchronous reset in the middle of a pulse
        bus_write(3'd6, 32'h80);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_port !== 8'hA5 || pulse_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse: out=%h act=%b want A5 0", out_port, pulse_active);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_pulse(16'd5, 8'h01, 5);
        test_zero_len_status();
        test_retrigger();
        test_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
